gl_raster_ctrl: RTL and testbench
=================================

Name: gl_raster_ctrl

Overview:
Triangle dispatch controller that sits between the primitive-assembly triangle FIFO and gl_rasterizer.
- Pops one triangle (three 96-bit vertices) at a time and culls degenerate triangles.
- Launches the rasterizer with a start pulse, then waits for its done pulse.
- Guards each triangle with a watchdog and keeps frame statistics readable by the host.

Parameters:
VERTEX_TYPE_SIZE, 96, width of one vertex word; x in [95:64], y in [63:32] (IEEE-754 single).
TIMEOUT_CYCLES, 1048576, maximum cycles allowed in WAIT before a timeout is declared.
CNT_W, 16, width of the triangle and cull statistics counters.

Ports:
clk  in  1  system clock; all logic is rising-edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  allows fetching new triangles; sampled only in IDLE.
clear_stats  in  1  one-cycle pulse; zeroes tri_count, cull_count and timeout_err.
tri_fifo_empty  in  1  triangle FIFO empty flag; the FIFO is first-word-fall-through.
tri_fifo_data  in  3*VERTEX_TYPE_SIZE  {v3,v2,v1}; v1 is in the LSBs.
tri_fifo_rd  out  1  pop strobe; combinational.
rast_v1, rast_v2, rast_v3  out  VERTEX_TYPE_SIZE each  registered vertices driven to the rasterizer.
rast_start  out  1  one-cycle launch pulse (drives fifo_ready).
rast_done  in  1  one-cycle completion pulse from the rasterizer (raster_ready).
busy  out  1  high whenever the state is not IDLE.
idle  out  1  high when state is IDLE and tri_fifo_empty is high.
timeout_err  out  1  sticky watchdog error flag.
tri_count  out  CNT_W  number of triangles completed.
cull_count  out  CNT_W  number of triangles culled.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; rast_start=0; rast_v1..3=0; timeout_err=0; tri_count=0; cull_count=0; watchdog=0. Reset mid-triangle abandons it and does not pop the FIFO.

State machine:
- IDLE:
  - tri_fifo_rd = enable & ~tri_fifo_empty, combinational.
  - When tri_fifo_rd is high, latch the three vertex slices into rast_v1..3 on the same edge, then go to CHECK.
- CHECK (1 cycle): the triangle is degenerate if either condition holds:
  - x1==x2==x3 or y1==y2==y3 (bitwise 32-bit equality);
  - any x or y has exponent 8'hFF (Inf/NaN).
  - Degenerate: cull_count+1, go to IDLE. Otherwise go to LAUNCH.
- LAUNCH (1 cycle): rast_start=1; watchdog cleared to 0; go to WAIT.
- WAIT:
  - rast_done=1: tri_count+1, go to IDLE.
  - Otherwise watchdog+1. When watchdog==TIMEOUT_CYCLES-1 without done: timeout_err<=1, go to IDLE.
  - If rast_done and the timeout condition occur in the same cycle, done wins.
- rast_done in any state other than WAIT is ignored.
- rast_v1..3 hold their values from capture until the next pop.

Timing and control rules:
- Latency: pop in cycle N, CHECK in N+1, rast_start in N+2. The earliest next pop is the cycle after rast_done. A culled triangle allows the next pop at N+2.
- enable deasserted mid-triangle: the current triangle completes normally; no further pops.
- clear_stats has priority over a same-cycle increment: the result is 0.
- Counters wrap modulo 2^CNT_W with no saturation.
- Exactly one tri_fifo_rd per triangle. rast_start is never asserted twice for one triangle.

Test Plan:
- Launch timing: reset, enable=1, push v1=(0,0), v2=(0x41200000 [10.0],0), v3=(0,0x41200000); pulse rast_done 20 cycles after rast_start -> tri_fifo_rd for exactly 1 cycle, rast_start exactly 2 cycles later, tri_count=1, busy low and idle high afterwards.
- Degenerate cull: push a triangle with all x=0x3F800000 -> no rast_start, cull_count=1, tri_count=0, next pop 2 cycles after the first.
- Inf/NaN cull: push a triangle with y2=0x7FC00000 -> culled, cull_count=1.
- Watchdog: TIMEOUT_CYCLES=16, never pulse rast_done -> timeout_err=1 after 16 WAIT cycles and the next triangle launches. Then a same-cycle done+timeout -> tri_count increments and timeout_err stays unchanged.
- Back-to-back and enable: queue 3 triangles and drop enable during the second WAIT -> second completes, third remains in the FIFO (no pop), tri_count=2. Re-enable -> third launches.
- Reset and stats: assert reset during WAIT -> all outputs 0, FIFO not popped. With CNT_W=2, complete 5 triangles -> tri_count=1. Pulse clear_stats coincident with a done -> tri_count=0.

Source files
------------

// File: rtl/gl_raster_ctrl.sv
// Triangle dispatch controller between the primitive FIFO and gl_rasterizer.
// Culls degenerate triangles, launches the rasterizer and guards it with a watchdog.
module gl_raster_ctrl #(
   parameter int VERTEX_TYPE_SIZE = 96,
   parameter int TIMEOUT_CYCLES   = 1048576,
   parameter int CNT_W            = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          clear_stats,
   input  logic                          tri_fifo_empty,
   input  logic [3*VERTEX_TYPE_SIZE-1:0] tri_fifo_data,
   output logic                          tri_fifo_rd,
   output logic [VERTEX_TYPE_SIZE-1:0]   rast_v1,
   output logic [VERTEX_TYPE_SIZE-1:0]   rast_v2,
   output logic [VERTEX_TYPE_SIZE-1:0]   rast_v3,
   output logic                          rast_start,
   input  logic                          rast_done,
   output logic                          busy,
   output logic                          idle,
   output logic                          timeout_err,
   output logic [CNT_W-1:0]              tri_count,
   output logic [CNT_W-1:0]              cull_count
);

   localparam int VW   = VERTEX_TYPE_SIZE;
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_LAUNCH,
      S_WAIT
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [WD_W-1:0]   r_wd;
   logic [VW-1:0]     r_v1;
   logic [VW-1:0]     r_v2;
   logic [VW-1:0]     r_v3;
   logic              r_terr;
   logic [CNT_W-1:0]  r_tri;
   logic [CNT_W-1:0]  r_cull;

   logic [31:0]       w_x1, w_x2, w_x3;
   logic [31:0]       w_y1, w_y2, w_y3;
   logic              w_flat;
   logic              w_nonfinite;
   logic              w_degen;
   logic              w_wd_exp;
   logic              w_rd;

   assign w_x1 = r_v1[95:64];
   assign w_y1 = r_v1[63:32];
   assign w_x2 = r_v2[95:64];
   assign w_y2 = r_v2[63:32];
   assign w_x3 = r_v3[95:64];
   assign w_y3 = r_v3[63:32];

   assign w_flat = ((w_x1 == w_x2) && (w_x2 == w_x3)) ||
                   ((w_y1 == w_y2) && (w_y2 == w_y3));

   // exponent all-ones covers both Inf and NaN
   assign w_nonfinite = (w_x1[30:23] == 8'hFF) || (w_y1[30:23] == 8'hFF) ||
                        (w_x2[30:23] == 8'hFF) || (w_y2[30:23] == 8'hFF) ||
                        (w_x3[30:23] == 8'hFF) || (w_y3[30:23] == 8'hFF);

   assign w_degen  = w_flat || w_nonfinite;
   assign w_wd_exp = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_rd) w_next = S_CHECK;
         S_CHECK:  w_next = w_degen ? S_IDLE : S_LAUNCH;
         S_LAUNCH: w_next = S_WAIT;
         S_WAIT:   if (rast_done || w_wd_exp) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // pop is gated by reset so an in-reset cycle never consumes a triangle
   always_comb begin
      w_rd       = (r_state == S_IDLE) && enable && !tri_fifo_empty && !reset;
      rast_start = (r_state == S_LAUNCH);
      busy       = (r_state != S_IDLE);
      idle       = (r_state == S_IDLE) && tri_fifo_empty;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_v1 <= '0;
         r_v2 <= '0;
         r_v3 <= '0;
         r_wd <= '0;
      end else begin
         if (w_rd) begin
            r_v1 <= tri_fifo_data[VW-1:0];
            r_v2 <= tri_fifo_data[2*VW-1:VW];
            r_v3 <= tri_fifo_data[3*VW-1:2*VW];
         end
         if (r_state == S_LAUNCH)
            r_wd <= '0;
         else if (r_state == S_WAIT && !rast_done)
            r_wd <= r_wd + WD_W'(1);
      end
   end

   // clear_stats overrides any same-cycle increment; done beats timeout
   always_ff @(posedge clk) begin
      if (reset || clear_stats) begin
         r_tri  <= '0;
         r_cull <= '0;
         r_terr <= 1'b0;
      end else begin
         if (r_state == S_CHECK && w_degen)
            r_cull <= r_cull + CNT_W'(1);
         if (r_state == S_WAIT) begin
            if (rast_done)
               r_tri <= r_tri + CNT_W'(1);
            else if (w_wd_exp)
               r_terr <= 1'b1;
         end
      end
   end

   assign tri_fifo_rd = w_rd;
   assign rast_v1     = r_v1;
   assign rast_v2     = r_v2;
   assign rast_v3     = r_v3;
   assign timeout_err = r_terr;
   assign tri_count   = r_tri;
   assign cull_count  = r_cull;

endmodule

// File: tb/tb_gl_raster_ctrl.sv
// Directed bench for gl_raster_ctrl with a small FWFT FIFO model.
// Runs with TIMEOUT_CYCLES=24 and CNT_W=2 so watchdog and wrap are reachable.
module tb_gl_raster_ctrl;

   localparam int VW = 96;
   localparam int TO = 24;
   localparam int CW = 2;

   localparam logic [31:0] F0   = 32'h00000000;
   localparam logic [31:0] F1   = 32'h3F800000;
   localparam logic [31:0] F2   = 32'h40000000;
   localparam logic [31:0] F10  = 32'h41200000;
   localparam logic [31:0] FNAN = 32'h7FC00000;
   localparam logic [31:0] FINF = 32'h7F800000;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            enable = 1'b0;
   logic            clear_stats = 1'b0;
   logic            rast_done = 1'b0;
   logic            tri_fifo_empty;
   logic [3*VW-1:0] tri_fifo_data;
   logic            tri_fifo_rd;
   logic [VW-1:0]   rast_v1, rast_v2, rast_v3;
   logic            rast_start, busy, idle, timeout_err;
   logic [CW-1:0]   tri_count, cull_count;

   logic [3*VW-1:0] mem [0:15];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int pop_cnt = 0;
   int start_cnt = 0;
   int cyc = 0;
   int st_cyc = 0;
   int rd_cyc [0:63];

   int n_cmp = 0;
   int n_err = 0;

   gl_raster_ctrl #(
      .VERTEX_TYPE_SIZE(VW),
      .TIMEOUT_CYCLES(TO),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .clear_stats(clear_stats),
      .tri_fifo_empty(tri_fifo_empty),
      .tri_fifo_data(tri_fifo_data),
      .tri_fifo_rd(tri_fifo_rd),
      .rast_v1(rast_v1),
      .rast_v2(rast_v2),
      .rast_v3(rast_v3),
      .rast_start(rast_start),
      .rast_done(rast_done),
      .busy(busy),
      .idle(idle),
      .timeout_err(timeout_err),
      .tri_count(tri_count),
      .cull_count(cull_count)
   );

   always #5 clk = ~clk;

   assign tri_fifo_empty = (rd_ptr == wr_ptr);
   assign tri_fifo_data  = mem[rd_ptr % 16];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tri_fifo_rd) begin
         rd_ptr <= rd_ptr + 1;
         pop_cnt <= pop_cnt + 1;
         rd_cyc[pop_cnt % 64] <= cyc;
      end
      if (rast_start) begin
         start_cnt <= start_cnt + 1;
         st_cyc <= cyc;
      end
   end

   function automatic logic [3*VW-1:0] mk_tri(
      input logic [31:0] x1, y1, x2, y2, x3, y3);
      return {x3, y3, 32'h0, x2, y2, 32'h0, x1, y1, 32'h0};
   endfunction

   task automatic push(input logic [3*VW-1:0] t);
      mem[wr_ptr % 16] = t;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_start(input int budget, output bit ok);
      int s0;
      s0 = start_cnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (start_cnt != s0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_done();
      rast_done = 1'b1;
      @(negedge clk);
      rast_done = 1'b0;
   endtask

   task automatic clr();
      clear_stats = 1'b1;
      @(negedge clk);
      clear_stats = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
      n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle got %b want 1", idle); end
      n_cmp++; if (rast_start !== 1'b0) begin n_err++; $display("FAIL rst_start got %b want 0", rast_start); end
      n_cmp++; if (tri_count !== 2'd0 || cull_count !== 2'd0) begin n_err++; $display("FAIL rst_cnt got %0d/%0d want 0/0", tri_count, cull_count); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_terr got %b want 0", timeout_err); end
      n_cmp++; if ({rast_v1, rast_v2, rast_v3} !== '0) begin n_err++; $display("FAIL rst_vtx got %h want 0", rast_v1); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_launch();
      int p0;
      int s0;
      bit ok;
      p0 = pop_cnt;
      s0 = start_cnt;
      enable = 1'b1;
      push(mk_tri(F0, F0, F10, F0, F0, F10));
      wait_start(10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL launch_start got none want pulse"); end
      n_cmp++; if (st_cyc - rd_cyc[p0 % 64] !== 2) begin n_err++; $display("FAIL launch_lat got %0d want 2", st_cyc - rd_cyc[p0 % 64]); end
      n_cmp++; if (pop_cnt - p0 !== 1) begin n_err++; $display("FAIL launch_pops got %0d want 1", pop_cnt - p0); end
      n_cmp++; if (rast_v2 !== {F10, F0, 32'h0}) begin n_err++; $display("FAIL launch_v2 got %h want %h", rast_v2, {F10, F0, 32'h0}); end
      n_cmp++; if (rast_v3 !== {F0, F10, 32'h0}) begin n_err++; $display("FAIL launch_v3 got %h want %h", rast_v3, {F0, F10, 32'h0}); end
      repeat (19) @(negedge clk);
      n_cmp++; if (busy !== 1'b1 || tri_count !== 2'd0) begin n_err++; $display("FAIL launch_wait got busy=%b cnt=%0d want 1/0", busy, tri_count); end
      pulse_done();
      n_cmp++; if (tri_count !== 2'd1) begin n_err++; $display("FAIL launch_cnt got %0d want 1", tri_count); end
      n_cmp++; if (busy !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL launch_idle got busy=%b idle=%b want 0/1", busy, idle); end
      n_cmp++; if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL launch_starts got %0d want 1", start_cnt - s0); end
   endtask

   task automatic test_cull();
      int p0;
      int s0;
      bit ok;
      clr();
      p0 = pop_cnt;
      s0 = start_cnt;
      push(mk_tri(F1, F0, F1, F2, F1, F10));
      push(mk_tri(F0, F0, F2, F0, F0, F2));
      wait_start(10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL cull_start got none want pulse"); end
      n_cmp++; if (rd_cyc[(p0 + 1) % 64] - rd_cyc[p0 % 64] !== 2) begin n_err++; $display("FAIL cull_gap got %0d want 2", rd_cyc[(p0 + 1) % 64] - rd_cyc[p0 % 64]); end
      n_cmp++; if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL cull_starts got %0d want 1", start_cnt - s0); end
      n_cmp++; if (cull_count !== 2'd1 || tri_count !== 2'd0) begin n_err++; $display("FAIL cull_cnt got %0d/%0d want 1/0", cull_count, tri_count); end
      pulse_done();
      n_cmp++; if (tri_count !== 2'd1) begin n_err++; $display("FAIL cull_tri got %0d want 1", tri_count); end
   endtask

   task automatic test_nonfinite();
      int s0;
      clr();
      s0 = start_cnt;
      push(mk_tri(F0, F0, F10, FNAN, F0, F10));
      repeat (4) @(negedge clk);
      n_cmp++; if (cull_count !== 2'd1) begin n_err++; $display("FAIL nan_cull got %0d want 1", cull_count); end
      push(mk_tri(F0, F0, F10, F0, FINF, F10));
      repeat (4) @(negedge clk);
      n_cmp++; if (cull_count !== 2'd2) begin n_err++; $display("FAIL inf_cull got %0d want 2", cull_count); end
      push(mk_tri(F0, F2, F10, F2, F1, F2));
      repeat (4) @(negedge clk);
      n_cmp++; if (cull_count !== 2'd3) begin n_err++; $display("FAIL flaty_cull got %0d want 3", cull_count); end
      n_cmp++; if (start_cnt - s0 !== 0 || tri_count !== 2'd0) begin n_err++; $display("FAIL nan_nostart got %0d/%0d want 0/0", start_cnt - s0, tri_count); end
   endtask

   task automatic test_watchdog();
      bit ok;
      clr();
      push(mk_tri(F0, F0, F10, F0, F0, F10));
      push(mk_tri(F0, F0, F2, F0, F0, F2));
      wait_start(10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL wd_start1 got none want pulse"); end
      repeat (TO - 1) @(negedge clk);
      n_cmp++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL wd_early got terr=%b busy=%b want 0/1", timeout_err, busy); end
      @(negedge clk);
      n_cmp++; if (timeout_err !== 1'b1 || tri_count !== 2'd0) begin n_err++; $display("FAIL wd_fire got terr=%b cnt=%0d want 1/0", timeout_err, tri_count); end
      wait_start(10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL wd_start2 got none want pulse"); end
      repeat (TO - 1) @(negedge clk);
      pulse_done();
      n_cmp++; if (tri_count !== 2'd1 || timeout_err !== 1'b1) begin n_err++; $display("FAIL wd_tie got cnt=%0d terr=%b want 1/1", tri_count, timeout_err); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wd_tie_busy got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int p0;
      int s0;
      bit ok;
      clr();
      p0 = pop_cnt;
      s0 = start_cnt;
      push(mk_tri(F0, F0, F10, F0, F0, F10));
      push(mk_tri(F0, F0, F2, F0, F0, F2));
      push(mk_tri(F1, F1, F10, F1, F1, F10));
      wait_start(10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_start1 got none want pulse"); end
      repeat (3) @(negedge clk);
      pulse_done();
      wait_start(10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_start2 got none want pulse"); end
      enable = 1'b0;
      repeat (3) @(negedge clk);
      pulse_done();
      repeat (8) @(negedge clk);
      n_cmp++; if (pop_cnt - p0 !== 2 || start_cnt - s0 !== 2) begin n_err++; $display("FAIL b2b_hold got pops=%0d starts=%0d want 2/2", pop_cnt - p0, start_cnt - s0); end
      n_cmp++; if (tri_count !== 2'd2) begin n_err++; $display("FAIL b2b_cnt got %0d want 2", tri_count); end
      n_cmp++; if (busy !== 1'b0 || idle !== 1'b0) begin n_err++; $display("FAIL b2b_flags got busy=%b idle=%b want 0/0", busy, idle); end
      enable = 1'b1;
      wait_start(10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_start3 got none want pulse"); end
      n_cmp++; if (rast_v1 !== {F1, F1, 32'h0}) begin n_err++; $display("FAIL b2b_v1 got %h want %h", rast_v1, {F1, F1, 32'h0}); end
      pulse_done();
      n_cmp++; if (tri_count !== 2'd3) begin n_err++; $display("FAIL b2b_cnt3 got %0d want 3", tri_count); end
   endtask

   task automatic test_reset_stats();
      int p0;
      bit ok;
      push(mk_tri(F0, F0, F10, F0, F0, F10));
      push(mk_tri(F0, F0, F2, F0, F0, F2));
      wait_start(10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rs_start got none want pulse"); end
      p0 = pop_cnt;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (pop_cnt !== p0) begin n_err++; $display("FAIL rs_nopop got %0d want %0d", pop_cnt, p0); end
      n_cmp++; if (busy !== 1'b0 || rast_start !== 1'b0) begin n_err++; $display("FAIL rs_busy got busy=%b start=%b want 0/0", busy, rast_start); end
      n_cmp++; if (tri_count !== 2'd0 || rast_v1 !== '0) begin n_err++; $display("FAIL rs_clear got cnt=%0d v1=%h want 0/0", tri_count, rast_v1); end
      reset = 1'b0;
      wait_start(10, ok);
      n_cmp++; if (!ok || pop_cnt !== p0 + 1) begin n_err++; $display("FAIL rs_resume got ok=%b pops=%0d want 1/%0d", ok, pop_cnt, p0 + 1); end
      pulse_done();
      clr();
      for (int i = 0; i < 5; i++) begin
         push(mk_tri(F0, F0, F10, F0, F0, F10));
         wait_start(10, ok);
         n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_start%0d got none want pulse", i); end
         pulse_done();
      end
      n_cmp++; if (tri_count !== 2'd1) begin n_err++; $display("FAIL wrap_cnt got %0d want 1", tri_count); end
      push(mk_tri(F0, F0, F10, F0, F0, F10));
      wait_start(10, ok);
      rast_done = 1'b1;
      clear_stats = 1'b1;
      @(negedge clk);
      rast_done = 1'b0;
      clear_stats = 1'b0;
      n_cmp++; if (tri_count !== 2'd0 || busy !== 1'b0) begin n_err++; $display("FAIL clr_prio got cnt=%0d busy=%b want 0/0", tri_count, busy); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_launch();
      test_cull();
      test_nonfinite();
      test_watchdog();
      test_back_to_back();
      test_reset_stats();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
